norm_quant_pipe: RTL and testbench

Multi-lane, parametrised fixed-point normalise/requantise pipeline: per lane, out = sat((data × gain + round) >>> shift + bias). It sits between the accumulator drain and the activation/writeback path. It succeeds the single-lane normaliser by adding:
- LANES parallel lanes
- configurable widths
- round-half-up
- output saturation with sticky overflow flags
- full valid/ready backpressure

---
 rtl/norm_quant_pipe_pkg.sv | 35 +++
 rtl/norm_quant_pipe_lane.sv | 109 ++++++++++
 rtl/norm_quant_pipe.sv | 85 ++++++++
 tb/tb_norm_quant_pipe.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/norm_quant_pipe_pkg.sv
// norm_quant_pipe shared definitions
// Width helpers, default widths and the output clamp

package norm_pkg;

    localparam int LANES_DEF  = 4;
    localparam int DATA_W_DEF = 32;
    localparam int GAIN_W_DEF = 16;
    localparam int BIAS_W_DEF = 32;
    localparam int OUT_W_DEF  = 16;
    localparam int CLAMP_W    = 64;

    function automatic int prod_w(input int dw, input int gw);
        return dw + gw;
    endfunction

    // Width at which shifted product plus bias cannot overflow
    function automatic int sum_w(input int pw, input int bw);
        return ((pw + 1 > bw) ? pw + 1 : bw) + 1;
    endfunction

    function automatic logic signed [CLAMP_W-1:0] sat_clamp(
        input logic signed [CLAMP_W-1:0] value,
        input int                        out_w
    );
        logic signed [CLAMP_W-1:0] hi;
        logic signed [CLAMP_W-1:0] lo;
        hi = (CLAMP_W'(1) << (out_w - 1)) - CLAMP_W'(1);
        lo = ~hi;
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/norm_quant_pipe_lane.sv
// norm_lane: one lane of the normalise/requantise datapath
// S1 operands, S2 product, S3 round+shift, S4 bias+clamp

module norm_lane
    import norm_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int GAIN_W  = GAIN_W_DEF,
    parameter int BIAS_W  = BIAS_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int SHIFT_W = $clog2(DATA_W + GAIN_W)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      load,
    input  logic signed [DATA_W-1:0]  data,
    input  logic signed [GAIN_W-1:0]  gain,
    input  logic signed [BIAS_W-1:0]  bias,
    input  logic        [SHIFT_W-1:0] shift,
    input  logic                      round_en,
    input  logic                      sat_en,
    output logic        [OUT_W-1:0]   result,
    output logic                      clamp
);

    localparam int P   = prod_w(DATA_W, GAIN_W);
    localparam int S_W = sum_w(P, BIAS_W);

    logic signed [DATA_W-1:0]  d1;
    logic signed [GAIN_W-1:0]  g1;
    logic signed [BIAS_W-1:0]  b1, b2, b3;
    logic        [SHIFT_W-1:0] s1, s2;
    logic                      r1, r2;
    logic                      c1, c2, c3;
    logic signed [P-1:0]       p2;
    logic        [P:0]         rnd;
    logic signed [P:0]         t;
    logic signed [P:0]         sh;
    logic signed [P:0]         sh3;
    logic signed [S_W-1:0]     sum;
    logic signed [CLAMP_W-1:0] wide;
    logic signed [CLAMP_W-1:0] clamped;

    // S1: capture the beat's operands
    always_ff @(posedge clk) begin
        if (en) begin
            d1 <= data;
            g1 <= gain;
            b1 <= bias;
            s1 <= shift;
            r1 <= round_en;
            c1 <= sat_en;
        end
    end

    // S2: full-precision signed product
    always_ff @(posedge clk) begin
        if (en) begin
            p2 <= P'(d1) * P'(g1);
            b2 <= b1;
            s2 <= s1;
            r2 <= r1;
            c2 <= c1;
        end
    end

    // Half-up rounding constant; shifts past P+1 fill with the sign
    always_comb begin
        rnd = '0;
        if (r2 && s2 != '0 && int'(s2) <= P)
            rnd = (P+1)'(1) << (s2 - SHIFT_W'(1));
        t  = {p2[P-1], p2} + rnd;
        sh = t >>> s2;
    end

    // S3: register the rounded, shifted value
    always_ff @(posedge clk) begin
        if (en) begin
            sh3 <= sh;
            b3  <= b2;
            c3  <= c2;
        end
    end

    // Bias add at overflow-free width, then clamp
    always_comb begin
        sum     = S_W'(sh3) + S_W'(b3);
        wide    = CLAMP_W'(sum);
        clamped = sat_clamp(wide, OUT_W);
    end

    // S4: output registers, loaded only by real beats
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            clamp  <= 1'b0;
        end else if (load) begin
            if (c3) begin
                result <= clamped[OUT_W-1:0];
                clamp  <= (clamped != wide);
            end else begin
                result <= sum[OUT_W-1:0];
                clamp  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/norm_quant_pipe.sv
// norm_quant_pipe: multi-lane normalise/requantise pipeline
// Global-stall valid chain around LANES norm_lane datapaths

module norm_quant_pipe
    import norm_pkg::*;
#(
    parameter int LANES   = LANES_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int GAIN_W  = GAIN_W_DEF,
    parameter int BIAS_W  = BIAS_W_DEF,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int SHIFT_W = $clog2(DATA_W + GAIN_W)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic [LANES*GAIN_W-1:0]   gain,
    input  logic [LANES*BIAS_W-1:0]   bias,
    input  logic [SHIFT_W-1:0]        shift,
    input  logic                      round_en,
    input  logic                      sat_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*OUT_W-1:0]    out_data,
    output logic [LANES-1:0]          sat_flag,
    output logic [LANES-1:0]          sat_sticky,
    input  logic                      sat_clear
);

    logic advance;
    logic v1, v2, v3;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Valid chain; bubbles move with the stages
    always_ff @(posedge clk) begin
        if (reset) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_valid <= 1'b0;
        end else if (advance) begin
            v1        <= in_valid;
            v2        <= v1;
            v3        <= v2;
            out_valid <= v3;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        norm_lane #(
            .DATA_W  (DATA_W),
            .GAIN_W  (GAIN_W),
            .BIAS_W  (BIAS_W),
            .OUT_W   (OUT_W),
            .SHIFT_W (SHIFT_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .en       (advance),
            .load     (advance && v3),
            .data     (in_data[i*DATA_W +: DATA_W]),
            .gain     (gain[i*GAIN_W +: GAIN_W]),
            .bias     (bias[i*BIAS_W +: BIAS_W]),
            .shift    (shift),
            .round_en (round_en),
            .sat_en   (sat_en),
            .result   (out_data[i*OUT_W +: OUT_W]),
            .clamp    (sat_flag[i])
        );
    end

    // Sticky clamp record; a new clamp beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset)
            sat_sticky <= '0;
        else
            sat_sticky <= (sat_clear ? '0 : sat_sticky)
                        | ({LANES{out_valid && out_ready}} & sat_flag);
    end

endmodule

// File: tb/tb_norm_quant_pipe.sv
// tb_norm_quant_pipe: directed vectors for norm_quant_pipe
// Hand-computed expectations, one check task for every comparison

module tb_norm_quant_pipe;

    localparam int LANES   = 4;
    localparam int DATA_W  = 32;
    localparam int GAIN_W  = 16;
    localparam int BIAS_W  = 32;
    localparam int OUT_W   = 16;
    localparam int SHIFT_W = 6;

    logic                    clk;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data;
    logic [LANES*GAIN_W-1:0] gain;
    logic [LANES*BIAS_W-1:0] bias;
    logic [SHIFT_W-1:0]      shift;
    logic                    round_en;
    logic                    sat_en;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*OUT_W-1:0]  out_data;
    logic [LANES-1:0]        sat_flag;
    logic [LANES-1:0]        sat_sticky;
    logic                    sat_clear;

    longint ld [LANES];
    longint lg [LANES];
    longint lb [LANES];

    int tests = 0;
    int fails = 0;

    norm_quant_pipe #(
        .LANES   (LANES),
        .DATA_W  (DATA_W),
        .GAIN_W  (GAIN_W),
        .BIAS_W  (BIAS_W),
        .OUT_W   (OUT_W),
        .SHIFT_W (SHIFT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .gain       (gain),
        .bias       (bias),
        .shift      (shift),
        .round_en   (round_en),
        .sat_en     (sat_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .sat_flag   (sat_flag),
        .sat_sticky (sat_sticky),
        .sat_clear  (sat_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        in_data = '0;
        gain    = '0;
        bias    = '0;
        for (int i = 0; i < LANES; i++) begin
            in_data[i*DATA_W +: DATA_W] = DATA_W'(ld[i]);
            gain[i*GAIN_W +: GAIN_W]    = GAIN_W'(lg[i]);
            bias[i*BIAS_W +: BIAS_W]    = BIAS_W'(lb[i]);
        end
    end

    task automatic check(input string tag, input longint got,
                         input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint lane(input int i);
        return longint'($signed(out_data[i*OUT_W +: OUT_W]));
    endfunction

    function automatic longint sval(input int k, input int i);
        longint v;
        v = 100 + k + 1000 * i;
        return (i % 2 == 1) ? -v : v;
    endfunction

    function automatic logic [LANES*OUT_W-1:0] exp_pack(input int k);
        logic [LANES*OUT_W-1:0] r;
        for (int i = 0; i < LANES; i++)
            r[i*OUT_W +: OUT_W] = OUT_W'(sval(k, i));
        return r;
    endfunction

    task automatic set_all(input longint d, input longint g,
                           input longint b);
        for (int i = 0; i < LANES; i++) begin
            ld[i] = d;
            lg[i] = g;
            lb[i] = b;
        end
    endtask

    // One beat through an empty pipe; returns at the negedge with it on out
    task automatic run1(input string tag, input int sh,
                        input bit rnd, input bit sat);
        int n;
        @(negedge clk);
        shift    = SHIFT_W'(sh);
        round_en = rnd;
        sat_en   = sat;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 12) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_latency"}, n, 4);
        @(negedge clk);
    endtask

    initial begin
        int sent;
        int got;
        int hi_cnt;
        bit fire;
        logic [LANES*OUT_W-1:0] held;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sat_clear = 1'b0;
        shift     = '0;
        round_en  = 1'b0;
        sat_en    = 1'b0;
        held      = '0;
        set_all(0, 0, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_sticky", sat_sticky, 0);

        // 1000 * 1.0 (Q8.8) >> 8 + 5
        set_all(1000, 256, 5);
        run1("basic", 8, 1'b0, 1'b1);
        for (int i = 0; i < LANES; i++)
            check($sformatf("basic_l%0d", i), lane(i), 1005);
        check("basic_flag", sat_flag, 0);

        // Half-up vs truncate on +/-1.5
        set_all(3, 1, 0);
        ld[1] = -3;
        ld[3] = -3;
        run1("round", 1, 1'b1, 1'b1);
        check("round_pos", lane(0), 2);
        check("round_neg", lane(1), -1);
        check("round_neg3", lane(3), -1);
        run1("trunc", 1, 1'b0, 1'b1);
        check("trunc_pos", lane(0), 1);
        check("trunc_neg", lane(1), -2);

        // Clamp high/low, pass-through lanes unaffected
        set_all(100, 1, 0);
        ld[0] = 40000;
        ld[1] = -40000;
        ld[3] = -100;
        run1("sat", 0, 1'b0, 1'b1);
        check("sat_hi", lane(0), 32767);
        check("sat_lo", lane(1), -32768);
        check("sat_pass", lane(2), 100);
        check("sat_passn", lane(3), -100);
        check("sat_flag", sat_flag, 4'b0011);
        @(posedge clk);
        #1 check("sat_sticky", sat_sticky, 4'b0011);

        // Same beat, wrapping instead of clamping
        run1("wrap", 0, 1'b0, 1'b0);
        check("wrap_hi", lane(0), -25536);
        check("wrap_lo", lane(1), 25536);
        check("wrap_flag", sat_flag, 0);
        @(posedge clk);
        #1 check("wrap_sticky", sat_sticky, 4'b0011);

        // Shift near P: sign fill then bias
        set_all(-5, 1, 1);
        ld[1] = 5;
        ld[3] = 5;
        lb[2] = 0;
        lb[3] = 0;
        run1("bigsh", 47, 1'b0, 1'b1);
        check("bigsh_neg_b1", lane(0), 0);
        check("bigsh_pos_b1", lane(1), 1);
        check("bigsh_neg_b0", lane(2), -1);
        check("bigsh_pos_b0", lane(3), 0);

        // Clear alone, then clear colliding with a new clamp
        @(negedge clk);
        sat_clear = 1'b1;
        @(negedge clk);
        check("clear", sat_sticky, 0);
        set_all(100, 1, 0);
        ld[2] = 40000;
        run1("clrset", 0, 1'b0, 1'b1);
        check("clrset_flag", sat_flag, 4'b0100);
        @(posedge clk);
        #1 sat_clear = 1'b0;
        check("clrset_sticky", sat_sticky, 4'b0100);

        // 20-beat stream with a 3-cycle downstream stall
        set_all(0, 1, 0);
        sent = 0;
        got  = 0;
        for (int c = 0; c < 80 && got < 20; c++) begin
            @(negedge clk);
            out_ready = !(c >= 8 && c <= 10);
            sat_en    = 1'b0;
            shift     = '0;
            for (int i = 0; i < LANES; i++)
                ld[i] = sval(sent, i);
            in_valid = (sent < 20);
            #1;
            if (c == 8) begin
                check("stall_valid", out_valid, 1);
                held = out_data;
            end
            if (c >= 8 && c <= 10)
                check($sformatf("stall_ready_c%0d", c), in_ready, 0);
            if (c >= 9 && c <= 10)
                check($sformatf("stall_hold_c%0d", c), out_data, held);
            if (out_valid && out_ready) begin
                check($sformatf("stream_%0d", got), out_data, exp_pack(got));
                got++;
            end
            fire = in_valid && in_ready;
            @(posedge clk);
            if (fire) sent++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_count", got, 20);
        repeat (6) begin
            @(negedge clk);
            if (out_valid) got++;
        end
        check("stream_nodup", got, 20);

        // Reset with 3 beats in flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst2_out_valid", out_valid, 0);
        check("rst2_in_ready", in_ready, 1);
        check("rst2_out_data", out_data, 0);
        check("rst2_sticky", sat_sticky, 0);
        hi_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) hi_cnt++;
        end
        check("rst2_no_out", hi_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
